mfcc_frame_collector: RTL and testbench

Downstream of the DCT-II scaling stage. Collects each contiguous burst of scaled DCT-II outputs into one complete MFCC feature frame and validates its length. Double-buffers frames and replays each accepted frame as a backpressured stream (valid/ready/last) to the VAD classifier. Malformed or overflowing bursts are dropped whole and flagged, so the classifier only ever sees complete 13-coefficient frames.

---
 rtl/mfcc_pkg.sv | 30 +++
 rtl/mfcc_frame_bank.sv | 44 ++++
 rtl/mfcc_frame_collector.sv | 214 +++++++++++++++++++++
 tb/tb_mfcc_frame_collector.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared MFCC frame constants, feature word type and FSM state encodings
//
// Purpose: constants and types common to the DCT-II stage, the frame
// collector and the VAD classifier.
//   N_FEAT     : coefficients per MFCC frame
//   DATA_W     : feature word width (IEEE-754 single, carried untouched)
//   CNT_W      : committed-frame counter width
//   feat_t     : one feature word
//   wr_state_e : collector write-side states
//   rd_state_e : collector read-side states
package mfcc_pkg;

  localparam int N_FEAT = 13;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] feat_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/mfcc_frame_bank.sv
// rtl/mfcc_frame_bank.sv - two-bank feature frame register file with registered read
//
// Purpose: holds two complete frames so one can be filled while the other drains.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset (read register only)
//   we, wr_bank,
//   wr_idx, wr_data    : write port
//   re, rd_bank, rd_idx: read port; rd_data updates only when re=1 so the
//                        presented word holds through consumer stalls
//   rd_data            : registered read data, 0 after reset
module mfcc_frame_bank #(
  parameter int N_FEAT = mfcc_pkg::N_FEAT,
  parameter int DATA_W = mfcc_pkg::DATA_W,
  parameter int IDX_W  = $clog2(N_FEAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic              rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][N_FEAT];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_bank][rd_idx];
    end
  end

endmodule

// File: rtl/mfcc_frame_collector.sv
// rtl/mfcc_frame_collector.sv - collects DCT-II bursts into MFCC frames and replays them as a stream
//
// Purpose: length-checks each contiguous input burst, double-buffers good
// frames and streams them to the VAD classifier with valid/ready/last.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   tvalid_dct2_feat, dct2_feat: input burst (valid held high for whole burst)
//   tvalid_mfcc_feat, tready_mfcc_feat, mfcc_feat, tlast_mfcc_feat: output stream
//   frame_err                 : pulse, burst length wrong, burst dropped
//   overflow                  : pulse, no free bank at burst start, burst dropped
//   frame_cnt                 : committed frame count (wraps)
module mfcc_frame_collector #(
  parameter int N_FEAT = mfcc_pkg::N_FEAT,
  parameter int DATA_W = mfcc_pkg::DATA_W,
  parameter int CNT_W  = mfcc_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tvalid_dct2_feat,
  input  logic [DATA_W-1:0] dct2_feat,
  output logic              tvalid_mfcc_feat,
  input  logic              tready_mfcc_feat,
  output logic [DATA_W-1:0] mfcc_feat,
  output logic              tlast_mfcc_feat,
  output logic              frame_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);
  import mfcc_pkg::*;

  // Write index must reach N_FEAT to tell a complete burst from a long one.
  localparam int WI_W = $clog2(N_FEAT + 1);
  localparam int RI_W = $clog2(N_FEAT);
  localparam logic [WI_W-1:0] W_LAST = WI_W'(N_FEAT);
  localparam logic [RI_W-1:0] R_LAST = RI_W'(N_FEAT - 1);

  wr_state_e        wstate, wstate_n;
  logic [WI_W-1:0]  widx, widx_n;
  logic             wr_bank, wr_bank_n;
  logic [1:0]       full, full_n;
  logic             we, commit, err_n, ovf_n;
  logic [RI_W-1:0]  wr_idx;

  rd_state_e        rstate, rstate_n;
  logic [RI_W-1:0]  ridx, ridx_n, ridx_inc, rd_idx;
  logic             rd_bank, rd_bank_n, other_bank, rd_sel_bank;
  logic             tvalid_n, tlast_n, re, release_bank, handshake;

  // ---------------- write side ----------------
  always_comb begin
    wstate_n  = wstate;
    widx_n    = widx;
    wr_bank_n = wr_bank;
    we        = 1'b0;
    commit    = 1'b0;
    err_n     = 1'b0;
    ovf_n     = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (tvalid_dct2_feat) begin
          // A bank released by the reader at this same edge counts as free.
          if (!full[wr_bank] || (release_bank && (rd_bank == wr_bank))) begin
            we       = 1'b1;
            widx_n   = WI_W'(1);
            wstate_n = W_FILL;
          end else begin
            ovf_n    = 1'b1;
            wstate_n = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (tvalid_dct2_feat) begin
          if (widx < W_LAST) begin
            we     = 1'b1;
            widx_n = widx + 1'b1;
          end else begin
            err_n    = 1'b1;
            wstate_n = W_DROP;
          end
        end else begin
          if (widx == W_LAST) begin
            commit    = 1'b1;
            wr_bank_n = ~wr_bank;
          end else begin
            err_n = 1'b1;
          end
          wstate_n = W_IDLE;
        end
      end
      W_DROP: begin
        if (!tvalid_dct2_feat) begin
          wstate_n = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  assign wr_idx = (wstate == W_IDLE) ? '0 : widx[RI_W-1:0];

  always_comb begin
    full_n = full;
    if (release_bank) full_n[rd_bank] = 1'b0;
    if (commit)       full_n[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate    <= W_IDLE;
      widx      <= '0;
      wr_bank   <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wstate    <= wstate_n;
      widx      <= widx_n;
      wr_bank   <= wr_bank_n;
      full      <= full_n;
      frame_err <= err_n;
      overflow  <= ovf_n;
      if (commit) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---------------- read side ----------------
  assign handshake  = tvalid_mfcc_feat && tready_mfcc_feat;
  assign ridx_inc   = ridx + 1'b1;
  assign other_bank = ~rd_bank;

  always_comb begin
    rstate_n     = rstate;
    ridx_n       = ridx;
    rd_bank_n    = rd_bank;
    tvalid_n     = tvalid_mfcc_feat;
    tlast_n      = tlast_mfcc_feat;
    re           = 1'b0;
    rd_sel_bank  = rd_bank;
    rd_idx       = '0;
    release_bank = 1'b0;
    case (rstate)
      R_IDLE: begin
        if (full[rd_bank]) begin
          re       = 1'b1;
          ridx_n   = '0;
          tvalid_n = 1'b1;
          tlast_n  = 1'b0;
          rstate_n = R_SEND;
        end
      end
      R_SEND: begin
        if (handshake) begin
          if (ridx == R_LAST) begin
            release_bank = 1'b1;
            rd_bank_n    = other_bank;
            // Chain straight into the other bank so back-to-back frames have no bubble.
            if (full[other_bank]) begin
              re          = 1'b1;
              rd_sel_bank = other_bank;
              ridx_n      = '0;
              tlast_n     = 1'b0;
            end else begin
              tvalid_n = 1'b0;
              tlast_n  = 1'b0;
              rstate_n = R_IDLE;
            end
          end else begin
            re      = 1'b1;
            rd_idx  = ridx_inc;
            ridx_n  = ridx_inc;
            tlast_n = (ridx_inc == R_LAST);
          end
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate           <= R_IDLE;
      ridx             <= '0;
      rd_bank          <= 1'b0;
      tvalid_mfcc_feat <= 1'b0;
      tlast_mfcc_feat  <= 1'b0;
    end else begin
      rstate           <= rstate_n;
      ridx             <= ridx_n;
      rd_bank          <= rd_bank_n;
      tvalid_mfcc_feat <= tvalid_n;
      tlast_mfcc_feat  <= tlast_n;
    end
  end

  mfcc_frame_bank #(
    .N_FEAT (N_FEAT),
    .DATA_W (DATA_W),
    .IDX_W  (RI_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_bank (wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (dct2_feat),
    .re      (re),
    .rd_bank (rd_sel_bank),
    .rd_idx  (rd_idx),
    .rd_data (mfcc_feat)
  );

endmodule

// File: tb/tb_mfcc_frame_collector.sv
// tb/tb_mfcc_frame_collector.sv - self-checking bench for mfcc_frame_collector
module tb_mfcc_frame_collector;

  localparam int N  = 13;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tvalid_dct2_feat = 1'b0;
  logic [DW-1:0] dct2_feat = '0;
  logic          tvalid_mfcc_feat;
  logic          tready_mfcc_feat = 1'b0;
  logic [DW-1:0] mfcc_feat;
  logic          tlast_mfcc_feat;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] frame_cnt;

  mfcc_frame_collector #(.N_FEAT(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .tvalid_dct2_feat (tvalid_dct2_feat),
    .dct2_feat        (dct2_feat),
    .tvalid_mfcc_feat (tvalid_mfcc_feat),
    .tready_mfcc_feat (tready_mfcc_feat),
    .mfcc_feat        (mfcc_feat),
    .tlast_mfcc_feat  (tlast_mfcc_feat),
    .frame_err        (frame_err),
    .overflow         (overflow),
    .frame_cnt        (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Observation state (filled by the monitor)
  logic [DW-1:0] rx_q[$];
  bit            rx_last_q[$];
  int            rx_cyc_q[$];
  int            rx_frames = 0;
  int            err_seen = 0, ovf_seen = 0;
  int            err_cyc = -1, ovf_cyc = -1, first_valid_cyc = -1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_burst[$];
  int            exp_cnt = 0;
  int            burst_start_cyc = 0;

  // 0: tready driven directly, 1: random, 2: toggle each cycle
  int rdy_mode = 0;

  typedef struct {
    int len;
    int exp_frames;
    int exp_err;
    int exp_ovf;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("stall_valid", tvalid_mfcc_feat, 1);
        check("stall_data", mfcc_feat, prev_data);
        check("stall_last", tlast_mfcc_feat, prev_last);
      end
      if (tvalid_mfcc_feat && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tvalid_mfcc_feat && tready_mfcc_feat) begin
        rx_q.push_back(mfcc_feat);
        rx_last_q.push_back(tlast_mfcc_feat);
        rx_cyc_q.push_back(cyc);
        if (tlast_mfcc_feat) rx_frames++;
      end
      if (frame_err) begin err_seen++; err_cyc = cyc; end
      if (overflow)  begin ovf_seen++; ovf_cyc = cyc; end
      if (frame_err || overflow) check("err_ovf_exclusive", frame_err & overflow, 0);
      prev_stall = tvalid_mfcc_feat && !tready_mfcc_feat;
      prev_data  = mfcc_feat;
      prev_last  = tlast_mfcc_feat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      tready_mfcc_feat = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) tready_mfcc_feat = ~tready_mfcc_feat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_obs();
    rx_q.delete();
    rx_last_q.delete();
    rx_cyc_q.delete();
    exp_q.delete();
    err_seen = 0;
    ovf_seen = 0;
    err_cyc = -1;
    ovf_cyc = -1;
    first_valid_cyc = -1;
  endtask

  // Called at posedge+1; word i is driven at burst_start_cyc+i.
  task automatic send_burst(input int len, input logic [DW-1:0] base, input bit rnd);
    last_burst.delete();
    burst_start_cyc = cyc;
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] w;
      w = rnd ? DW'($urandom) : base + DW'(i);
      last_burst.push_back(w);
      tvalid_dct2_feat = 1'b1;
      dct2_feat = w;
      tick();
    end
    tvalid_dct2_feat = 1'b0;
    dct2_feat = '0;
  endtask

  task automatic accept_last();
    foreach (last_burst[i]) exp_q.push_back(last_burst[i]);
    exp_cnt++;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_data"}, rx_q[i], exp_q[i]);
      check({tag, "_last"}, rx_last_q[i], (i % N) == N - 1);
    end
  endtask

  task automatic check_no_bubble(input string tag, input int words);
    if (rx_cyc_q.size() >= words)
      check(tag, rx_cyc_q[words-1] - rx_cyc_q[0], words - 1);
    else
      check({tag, "_short"}, rx_cyc_q.size(), words);
  endtask

  initial begin
    tbl[0] = '{len: 13, exp_frames: 1, exp_err: 0, exp_ovf: 0};
    tbl[1] = '{len: 12, exp_frames: 0, exp_err: 1, exp_ovf: 0};
    tbl[2] = '{len: 15, exp_frames: 0, exp_err: 1, exp_ovf: 0};
    tbl[3] = '{len: 1,  exp_frames: 0, exp_err: 1, exp_ovf: 0};
    tbl[4] = '{len: 14, exp_frames: 0, exp_err: 1, exp_ovf: 0};
    tbl[5] = '{len: 13, exp_frames: 1, exp_err: 0, exp_ovf: 0};

    // Reset state
    settle(2);
    check("rst_tvalid", tvalid_mfcc_feat, 0);
    check("rst_data", mfcc_feat, 0);
    check("rst_tlast", tlast_mfcc_feat, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b1;
    tick();

    // Table: single frame, short and long bursts with ready held high
    tready_mfcc_feat = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_obs();
      send_burst(tbl[v].len, 32'h3F80_0000, 1'b0);
      if (tbl[v].exp_frames == 1) accept_last();
      settle(N + 8);
      compare_stream("tbl_stream");
      check("tbl_err", err_seen, tbl[v].exp_err);
      check("tbl_ovf", ovf_seen, tbl[v].exp_ovf);
      check("tbl_cnt", frame_cnt, exp_cnt % 65536);
      if (tbl[v].exp_frames == 1) begin
        check("tbl_latency", first_valid_cyc, burst_start_cyc + N - 1 + 3);
        check_no_bubble("tbl_drain", N);
      end
      if (tbl[v].exp_err == 1) begin
        check("tbl_err_cycle", err_cyc,
              burst_start_cyc + ((tbl[v].len < N) ? tbl[v].len : N) + 1);
      end
    end

    // Backpressure: ready toggling every cycle
    clear_obs();
    rdy_mode = 2;
    send_burst(N, 32'h4000_0000, 1'b0);
    accept_last();
    settle(45);
    rdy_mode = 0;
    tready_mfcc_feat = 1'b1;
    compare_stream("bp_stream");
    check("bp_err", err_seen, 0);

    // Overflow: both banks fill while ready is low, third burst dropped
    clear_obs();
    tready_mfcc_feat = 1'b0;
    send_burst(N, 32'h1000_0000, 1'b0); accept_last(); tick();
    send_burst(N, 32'h2000_0000, 1'b0); accept_last(); tick();
    send_burst(N, 32'h3000_0000, 1'b0); tick();
    settle(3);
    check("ovf_count", ovf_seen, 1);
    check("ovf_cycle", ovf_cyc, burst_start_cyc + 1);
    check("ovf_err", err_seen, 0);
    check("ovf_cnt", frame_cnt, exp_cnt % 65536);
    check("ovf_no_output", rx_q.size(), 0);
    tready_mfcc_feat = 1'b1;
    settle(40);
    compare_stream("ovf_stream");
    check_no_bubble("ovf_back_to_back", 2 * N);

    // Release/start collision on the same bank
    clear_obs();
    tready_mfcc_feat = 1'b0;
    send_burst(N, 32'h5000_0000, 1'b0); accept_last(); tick();
    send_burst(N, 32'h6000_0000, 1'b0); accept_last(); tick();
    settle(4);
    tready_mfcc_feat = 1'b1;
    settle(N - 1);
    send_burst(N, 32'h7000_0000, 1'b0); accept_last();
    settle(45);
    check("coll_ovf", ovf_seen, 0);
    check("coll_err", err_seen, 0);
    check("coll_cnt", frame_cnt, exp_cnt % 65536);
    compare_stream("coll_stream");

    // Reset in the middle of a burst
    clear_obs();
    for (int i = 0; i < N; i++) begin
      tvalid_dct2_feat = 1'b1;
      dct2_feat = 32'h8000_0000 + DW'(i);
      if (i == 6) begin
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tvalid", tvalid_mfcc_feat, 0);
        check("mid_rst_data", mfcc_feat, 0);
        check("mid_rst_tlast", tlast_mfcc_feat, 0);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        exp_cnt = 0;
      end
      if (i == 7) #2 rst = 1'b1;
      tick();
    end
    tvalid_dct2_feat = 1'b0;
    settle(20);
    check("mid_rst_frag_err", err_seen, 1);
    check("mid_rst_frag_out", rx_q.size(), 0);
    check("mid_rst_frag_cnt", frame_cnt, 0);
    clear_obs();
    send_burst(N, 32'h9000_0000, 1'b0); accept_last();
    settle(N + 8);
    compare_stream("post_rst_stream");
    check("post_rst_cnt", frame_cnt, exp_cnt % 65536);

    // Randomised bursts and ready against the frame-level model
    begin
      int committed_r, base_frames, exp_err;
      clear_obs();
      committed_r = 0;
      base_frames = rx_frames;
      exp_err = 0;
      rdy_mode = 1;
      for (int b = 0; b < 40; b++) begin
        int len;
        for (int t = 0; t < 300 && (committed_r - (rx_frames - base_frames)) > 1; t++) tick();
        len = ($urandom_range(0, 9) < 6) ? N : int'($urandom_range(1, 17));
        send_burst(len, '0, 1'b1);
        if (len == N) begin
          accept_last();
          committed_r++;
        end else begin
          exp_err++;
        end
        settle(int'($urandom_range(1, 3)));
      end
      for (int t = 0; t < 3000 && rx_q.size() < exp_q.size(); t++) tick();
      settle(5);
      rdy_mode = 0;
      compare_stream("rand_stream");
      check("rand_err", err_seen, exp_err);
      check("rand_ovf", ovf_seen, 0);
      check("rand_cnt", frame_cnt, exp_cnt % 65536);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
